bcd_conv_sched: RTL and testbench

//  Shares one serial shift-add-3 (double-dabble) binary-to-BCD engine among NUM_REQ

---
 rtl/bcd_conv_sched.sv | 110 +++++++++++
 tb/tb_bcd_conv_sched.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_sched.sv
// Round-robin shared serial double-dabble binary-to-BCD converter for NUM_REQ channels.
// One bit per clock: grant -> BIN_W shift cycles -> one DONE cycle with ack and result.
module bcd_conv_sched #(
   parameter int NUM_REQ = 3,
   parameter int BIN_W   = 6
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*BIN_W-1:0]     bin_in,
   output logic [NUM_REQ-1:0]           ack,
   output logic [NUM_REQ*7-1:0]         bcd_out,
   output logic                         busy,
   output logic [$clog2(NUM_REQ)-1:0]   gnt_id
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int CW = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [GW-1:0]    last_gnt;
   logic [BIN_W-1:0] sr;
   logic [2:0]       tens;
   logic [3:0]       ones;
   logic [CW-1:0]    cnt;

   logic             any;
   logic [GW-1:0]    pick;
   logic [3:0]       o_adj;
   logic [2:0]       t_adj;
   logic [BIN_W+6:0] sh;
   logic [2:0]       nt;
   logic [3:0]       no;
   logic [BIN_W-1:0] nsr;

   // Search starts just after the last served channel, wrapping, so nobody starves.
   always_comb begin
      int idx;
      any  = 1'b0;
      pick = '0;
      idx  = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = (int'(last_gnt) + i) % NUM_REQ;
         if (!any && req[idx]) begin
            any  = 1'b1;
            pick = GW'(idx);
         end
      end
   end

   always_comb begin
      o_adj = (ones >= 4'd5) ? ones + 4'd3 : ones;
      t_adj = (tens >= 3'd5) ? tens + 3'd3 : tens;
      sh    = {t_adj, o_adj, sr} << 1;
      nt    = sh[BIN_W+6:BIN_W+4];
      no    = sh[BIN_W+3:BIN_W];
      nsr   = sh[BIN_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt_id   <= '0;
         last_gnt <= GW'(NUM_REQ - 1);
         sr       <= '0;
         tens     <= '0;
         ones     <= '0;
         cnt      <= '0;
         ack      <= '0;
         bcd_out  <= '0;
         busy     <= 1'b0;
      end else begin
         ack <= '0;
         case (state)
            IDLE: begin
               if (any) begin
                  gnt_id <= pick;
                  sr     <= bin_in[pick*BIN_W +: BIN_W];
                  tens   <= '0;
                  ones   <= '0;
                  cnt    <= CW'(BIN_W);
                  busy   <= 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               tens <= nt;
               ones <= no;
               sr   <= nsr;
               cnt  <= cnt - CW'(1);
               // Final shift writes the result directly so it is valid throughout DONE.
               if (cnt == CW'(1)) begin
                  bcd_out[gnt_id*7 +: 7] <= {nt, no};
                  ack[gnt_id]            <= 1'b1;
                  state                  <= DONE;
               end
            end
            DONE: begin
               last_gnt <= gnt_id;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed bench for bcd_conv_sched: vector table plus reset, fairness and handshake sequences.
module tb_bcd_conv_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req;
   logic [17:0] bin_in;
   logic [2:0]  ack;
   logic [20:0] bcd_out;
   logic        busy;
   logic [1:0]  gnt_id;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   logic [6:0] model [3];

   typedef struct {
      int         ch;
      logic [5:0] bin;
      logic [6:0] exp;
   } vec_t;

   vec_t tbl [8];

   bcd_conv_sched #(.NUM_REQ(3), .BIN_W(6)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .bin_in  (bin_in),
      .ack     (ack),
      .bcd_out (bcd_out),
      .busy    (busy),
      .gnt_id  (gnt_id)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   function automatic logic [20:0] packed_model();
      return {model[2], model[1], model[0]};
   endfunction

   // Single-channel conversion with latency and pulse-width checks.
   task automatic run_one(input int ch, input logic [5:0] bin, input logic [6:0] expv);
      int t;
      int k;
      @(negedge clk);
      bin_in[ch*6 +: 6] = bin;
      req               = '0;
      req[ch]           = 1'b1;
      t = 0;
      do begin
         @(posedge clk); #1;
         t++;
      end while (!busy && t < 20);
      chk("grant", {31'd0, busy}, 32'd1);
      chk("gnt_id", {30'd0, gnt_id}, ch);
      k = cyc;
      repeat (5) @(posedge clk);
      #1;
      chk("ack_early", {29'd0, ack}, 32'd0);
      @(posedge clk); #1;
      chk("ack", {29'd0, ack}, 32'd1 << ch);
      chk("ack_latency", cyc - k, 32'd6);
      model[ch] = expv;
      chk("bcd_out", {11'd0, bcd_out}, {11'd0, packed_model()});
      req = '0;
      @(posedge clk); #1;
      chk("ack_pulse", {29'd0, ack}, 32'd0);
      chk("busy_end", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int t;
      int k;
      int last_ack;
      logic [6:0] exp4 [3];

      tbl[0] = '{0, 6'd63, 7'h63};
      tbl[1] = '{1, 6'd0,  7'h00};
      tbl[2] = '{2, 6'd9,  7'h09};
      tbl[3] = '{0, 6'd10, 7'h10};
      tbl[4] = '{1, 6'd45, 7'h45};
      tbl[5] = '{2, 6'd59, 7'h59};
      tbl[6] = '{0, 6'd1,  7'h01};
      tbl[7] = '{1, 6'd50, 7'h50};
      for (int i = 0; i < 3; i++) model[i] = '0;

      // Reset state and idle with no requests
      rst_n  = 1'b0;
      req    = '0;
      bin_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_bcd", {11'd0, bcd_out}, 32'd0);
      chk("rst_ack", {29'd0, ack}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_gnt", {30'd0, gnt_id}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_ack", {29'd0, ack}, 32'd0);

      for (int i = 0; i < 8; i++) run_one(tbl[i].ch, tbl[i].bin, tbl[i].exp);

      for (int b = 0; b < 64; b++)
         run_one(1, 6'(b), {3'(b / 10), 4'(b % 10)});

      // Reset on the third SHIFT cycle of a ch1 conversion
      @(negedge clk);
      bin_in[6 +: 6] = 6'd20;
      req = 3'b010;
      t = 0;
      do begin
         @(posedge clk); #1;
         t++;
      end while (!busy && t < 20);
      chk("abort_grant", {31'd0, busy}, 32'd1);
      req = '0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_bcd", {11'd0, bcd_out}, 32'd0);
      chk("abort_ack", {29'd0, ack}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_gnt", {30'd0, gnt_id}, 32'd0);
      for (int i = 0; i < 3; i++) model[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("abort_ack_hold", {29'd0, ack}, 32'd0);

      // Release with all channels requesting: order 0,1,2, acks 8 cycles apart
      @(negedge clk);
      rst_n  = 1'b1;
      bin_in = {6'd10, 6'd9, 6'd45};
      req    = 3'b111;
      exp4[0] = 7'h45;
      exp4[1] = 7'h09;
      exp4[2] = 7'h10;
      last_ack = 0;
      for (int n = 0; n < 3; n++) begin
         t = 0;
         do begin
            @(posedge clk); #1;
            t++;
         end while (ack == 3'b000 && t < 20);
         chk("rr_ack", {29'd0, ack}, 32'd1 << n);
         if (n > 0) chk("rr_spacing", cyc - last_ack, 32'd8);
         last_ack = cyc;
         model[n] = exp4[n];
         chk("rr_bcd", {11'd0, bcd_out}, {11'd0, packed_model()});
      end
      req = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rr_idle", {31'd0, busy}, 32'd0);

      // ch2 input changes and req drops right after grant
      @(negedge clk);
      bin_in[12 +: 6] = 6'd37;
      req = 3'b100;
      t = 0;
      do begin
         @(posedge clk); #1;
         t++;
      end while (!busy && t < 20);
      chk("drop_gnt", {30'd0, gnt_id}, 32'd2);
      k = cyc;
      @(negedge clk);
      bin_in[12 +: 6] = 6'd12;
      req = '0;
      t = 0;
      do begin
         @(posedge clk); #1;
         t++;
      end while (ack == 3'b000 && t < 20);
      chk("drop_ack", {29'd0, ack}, 32'd4);
      chk("drop_latency", cyc - k, 32'd6);
      model[2] = 7'h37;
      chk("drop_bcd", {11'd0, bcd_out}, {11'd0, packed_model()});
      repeat (3) @(posedge clk);
      #1;
      chk("drop_idle", {31'd0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
